bin2bcd_8: RTL and testbench
============================

# bin2bcd_8

Sequential binary-to-BCD converter feeding the 8-digit seven-segment decoder. It accepts an unsigned binary value on a start strobe and runs a shift-and-add-3 (double-dabble) iteration, one bit per clock. It then presents eight packed BCD digits on a 32-bit bus; digit 0, the least-significant, is in bits [3:0]. The result bus connects directly to the decoder's 32-bit digit input and holds steady between conversions.

## Interface
- BIN_W, 27, width of the binary input; legal range 1..32. 27 covers 0..134,217,727.
- iCLK  in  1  system clock; all state updates on its rising edge.
- iRST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- iSTART  in  1  start strobe; sampled only while oBUSY=0.
- iBIN  in  BIN_W  unsigned value; captured at the edge that accepts iSTART.
- oBUSY  out  1  high while a conversion is in progress.
- oDONE  out  1  one-cycle pulse; oDIG and oOVF are updated at the same edge that raises it.
- oDIG  out  32  packed BCD result, 4 bits per digit; held until the next completion.
- oOVF  out  1  saturation flag; updated together with oDIG.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - oBUSY=0.
  - On iSTART=1, load iBIN into the binary shift register, clear the 32-bit BCD scratch register, and load the bit counter with BIN_W.
  - Go to SHIFT.
- SHIFT, every cycle:
  - For each of the 8 scratch digits, add 3 to the digit if it is >= 5.
  - Shift {scratch, binary} left by one, so the binary MSB enters scratch bit 0.
  - Decrement the counter.
- Final shift (counter = 1):
  - Write the shifted result to oDIG, pulse oDONE, update oOVF.
  - Return to IDLE.
- iSTART while oBUSY=1 is ignored. There is no queueing and iBIN is not recaptured.
- oDIG never shows intermediate scratch values.
- Truncation: inputs above 99,999,999 lose their upper digits in the dabble. The natural result is BCD(iBIN mod 10^8).
- Counter width: $clog2(BIN_W+1) bits.

## Timing
- Reset values: state IDLE, oBUSY=0, oDONE=0, oDIG=32'h0, oOVF=0, scratch and counter 0.
- iSTART is accepted at edge E.
  - oBUSY is high for cycles E..E+BIN_W-1.
  - oDONE and the new oDIG/oOVF appear after edge E+BIN_W. Latency is BIN_W cycles.
- Back-to-back operation:
  - In the cycle oDONE is high, oBUSY=0, so a new iSTART is accepted at edge E+BIN_W+1.
  - Throughput is one conversion per BIN_W+1 cycles.
- Reset asserted mid-conversion aborts the conversion immediately. All outputs return to their reset values and no oDONE is issued.
- iSTART held high continuously starts a new conversion each time the block returns to IDLE.

## Configuration
- BIN2BCD_SAT_EN defined:
  - The comparison iBIN > 99,999,999 is registered at capture.
  - If true, completion drives oDIG=32'h99999999 and oOVF=1.
  - If false, the block produces the normal result with oOVF=0.
  - Latency is unchanged.
- BIN2BCD_SAT_EN undefined:
  - No comparator is built; oOVF is tied to 0.
  - Oversize inputs produce the truncated BCD(iBIN mod 10^8).

## Structure
- Shared package seg7_pkg holds:
  - DIGITS = 8
  - BCD_MAX = 99_999_999
  - the FSM state typedef (IDLE, SHIFT)
- Natural sub-module: bcd_add3, a combinational 4-bit corrector (out = in >= 5 ? in + 3 : in). It is instantiated once per digit inside bin2bcd_8.

## Test plan
- Reset, then idle 5 cycles -> oDIG=0, oBUSY=0, oDONE=0, oOVF=0.
- iBIN=12,345,678 with iSTART for one cycle -> oBUSY high for 27 cycles, then a single oDONE pulse with oDIG=32'h12345678; oDIG stays stable afterwards.
- Corner values:
  - iBIN=0 -> 32'h00000000.
  - iBIN=99,999,999 -> 32'h99999999 with oOVF=0.
  - iBIN=5 -> 32'h00000005.
- Oversize inputs:
  - iBIN=100,000,000 -> with BIN2BCD_SAT_EN: 32'h99999999, oOVF=1; without: 32'h00000000, oOVF=0.
  - iBIN=134,217,727 without the macro -> 32'h34217727.
- Conversion of 42, then iSTART with iBIN=7 at cycle 5 of the conversion -> exactly one oDONE, oDIG=32'h00000042. Then iSTART with iBIN=7 in the oDONE cycle -> second result 32'h00000007, with oDONE exactly 28 cycles after the first.
- iRST_N low at cycle 10 of a conversion -> all outputs 0 at once, no oDONE. After release, a conversion of 987 yields 32'h00000987.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: digit count,
// largest representable BCD value and the converter FSM state type.
package seg7_pkg;

  localparam int          DIGITS  = 8;
  localparam logic [31:0] BCD_MAX = 32'd99_999_999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bin2bcd_8_if.sv
// Start/result bus between a requester and the bin2bcd_8 converter.
// The converter (slave) drives busy/done/digits/overflow back to the master.
interface bin2bcd_8_if #(
  parameter int BIN_W = 27
);

  logic             iSTART;
  logic [BIN_W-1:0] iBIN;
  logic             oBUSY;
  logic             oDONE;
  logic [31:0]      oDIG;
  logic             oOVF;

  modport master (
    output iSTART, iBIN,
    input  oBUSY, oDONE, oDIG, oOVF
  );

  modport slave (
    input  iSTART, iBIN,
    output oBUSY, oDONE, oDIG, oOVF
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_8.sv
// Sequential shift-and-add-3 binary to 8-digit packed BCD converter.
// Optional saturation of inputs above 99,999,999 is enabled by BIN2BCD_SAT_EN.
module bin2bcd_8
  import seg7_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input logic         iCLK,
  input logic         iRST_N,
  bin2bcd_8_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state_reg;
  state_t           state_next;
  logic [BIN_W-1:0] bin_reg;
  logic [31:0]      scratch_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      dig_reg;
  logic             done_reg;

  logic [31:0]      corrected;
  logic [31:0]      shifted;
  logic [31:0]      result_dig;
  logic             accept;
  logic             last_shift;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .digit     (scratch_reg[gi*4 +: 4]),
        .corrected (corrected[gi*4 +: 4])
      );
    end
  endgenerate

  // Corrected scratch shifts left; the binary MSB enters digit 0 bit 0.
  assign shifted    = {corrected[30:0], bin_reg[BIN_W-1]};
  assign accept     = (state_reg == IDLE) && bus.iSTART;
  assign last_shift = (state_reg == SHIFT) && (cnt_reg == CNT_W'(1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.iSTART) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      dig_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        bin_reg     <= bus.iBIN;
        scratch_reg <= '0;
        cnt_reg     <= CNT_W'(BIN_W);
      end else if (state_reg == SHIFT) begin
        scratch_reg <= shifted;
        bin_reg     <= bin_reg << 1;
        cnt_reg     <= cnt_reg - CNT_W'(1);
        if (last_shift) begin
          dig_reg  <= result_dig;
          done_reg <= 1'b1;
        end
      end
    end
  end

`ifdef BIN2BCD_SAT_EN
  logic big_reg;
  logic ovf_reg;

  // Oversize flag is taken from the raw input so the dabble itself stays untouched.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      big_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (accept) begin
        big_reg <= (33'(bus.iBIN) > 33'(BCD_MAX));
      end
      if (last_shift) begin
        ovf_reg <= big_reg;
      end
    end
  end

  assign result_dig = big_reg ? 32'h9999_9999 : shifted;
  assign bus.oOVF   = ovf_reg;
`else
  assign result_dig = shifted;
  assign bus.oOVF   = 1'b0;
`endif

  assign bus.oBUSY = (state_reg == SHIFT);
  assign bus.oDONE = done_reg;
  assign bus.oDIG  = dig_reg;

endmodule

// File: tb/tb_bin2bcd_8.sv
// Directed bench for bin2bcd_8: expected results are queued at each start and
// popped by a monitor on every done pulse; timing checks run inline.
module tb_bin2bcd_8;

  localparam int BIN_W = 27;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  bin2bcd_8_if #(.BIN_W(BIN_W)) bif ();

  bin2bcd_8 #(.BIN_W(BIN_W)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bif)
  );

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [32:0] exp_q[$];

  always @(posedge iCLK) cyc++;

  // Reference: saturate (when enabled) or keep the low 8 decimal digits.
  function automatic logic [32:0] model(input longint unsigned v);
    logic [31:0] d;
    longint unsigned r;
    d = '0;
`ifdef BIN2BCD_SAT_EN
    if (v > 64'd99_999_999) return {1'b1, 32'h9999_9999};
`endif
    r = v % 64'd100_000_000;
    for (int i = 0; i < 8; i++) begin
      d[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, d};
  endfunction

  always @(negedge iCLK) begin
    if (bif.oDONE === 1'b1) begin
      logic [32:0] e;
      done_cnt++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL spurious_done obs=%0d exp=%0d", 1, 0);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (bif.oDIG === e[31:0]) else begin
          fails++;
          $error("FAIL result_dig obs=%h exp=%h", bif.oDIG, e[31:0]);
        end
        tests++;
        assert (bif.oOVF === e[32]) else begin
          fails++;
          $error("FAIL result_ovf obs=%b exp=%b", bif.oOVF, e[32]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start once the converter is idle; returns after the accepting edge.
  task automatic start(input logic [31:0] v, input bit drop);
    int n = 0;
    while (bif.oBUSY !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk("idle_wait_timeout", 32'(n < 60), 32'd1);
    bif.iBIN   = v[BIN_W-1:0];
    bif.iSTART = 1'b1;
    tick();
    if (drop) bif.iSTART = 1'b0;
  endtask

  task automatic wait_done(output int c);
    int n = 0;
    tick();
    while (bif.oDONE !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(n < 60), 32'd1);
    c = cyc;
  endtask

  task automatic convert(input logic [31:0] v, input logic [32:0] e);
    int c;
    exp_q.push_back(e);
    start(v, 1'b1);
    wait_done(c);
  endtask

  initial begin
    int n;
    int c1;
    int c2;
    int base;
    bif.iSTART = 1'b0;
    bif.iBIN   = '0;

    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (5) tick();
    chk("reset_dig", bif.oDIG, 32'h0);
    chk("reset_busy", 32'(bif.oBUSY), 32'd0);
    chk("reset_done", 32'(bif.oDONE), 32'd0);
    chk("reset_ovf", 32'(bif.oOVF), 32'd0);

    exp_q.push_back({1'b0, 32'h1234_5678});
    start(32'd12_345_678, 1'b1);
    n = 0;
    while (bif.oBUSY === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy_len", 32'(n), 32'd27);
    chk("done_after_busy", 32'(bif.oDONE), 32'd1);
    tick();
    chk("done_single_pulse", 32'(bif.oDONE), 32'd0);
    repeat (5) tick();
    chk("dig_hold", bif.oDIG, 32'h1234_5678);

    convert(32'd0, {1'b0, 32'h0000_0000});
    convert(32'd99_999_999, {1'b0, 32'h9999_9999});
    convert(32'd5, {1'b0, 32'h0000_0005});
    convert(32'd100_000_000, model(64'd100_000_000));
    convert(32'd134_217_727, model(64'd134_217_727));
    convert(32'd1_000_001, {1'b0, 32'h0100_0001});

    // A start during a conversion must be ignored; one in the done cycle is taken.
    exp_q.push_back({1'b0, 32'h0000_0042});
    start(32'd42, 1'b1);
    repeat (4) tick();
    bif.iBIN   = 27'd7;
    bif.iSTART = 1'b1;
    tick();
    bif.iSTART = 1'b0;
    base = done_cnt;
    wait_done(c1);
    chk("no_early_done", 32'(done_cnt), 32'(base));
    exp_q.push_back({1'b0, 32'h0000_0007});
    bif.iBIN   = 27'd7;
    bif.iSTART = 1'b1;
    tick();
    bif.iSTART = 1'b0;
    wait_done(c2);
    chk("back_to_back_gap", 32'(c2 - c1), 32'd28);

    // Held start restarts on every return to idle.
    exp_q.push_back(model(64'd3));
    exp_q.push_back(model(64'd3));
    start(32'd3, 1'b0);
    wait_done(c1);
    wait_done(c2);
    bif.iSTART = 1'b0;
    chk("held_start_gap", 32'(c2 - c1), 32'd28);

    start(32'd555, 1'b1);
    repeat (9) tick();
    iRST_N = 1'b0;
    #1;
    chk("abort_dig", bif.oDIG, 32'h0);
    chk("abort_busy", 32'(bif.oBUSY), 32'd0);
    chk("abort_done", 32'(bif.oDONE), 32'd0);
    chk("abort_ovf", 32'(bif.oOVF), 32'd0);
    base = done_cnt;
    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (30) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(base));
    convert(32'd987, {1'b0, 32'h0000_0987});

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
